filter_scan_controller: RTL

//  Sequences filter-scratchpad reads for the conv datapath. It walks num_filters consecutive filters
//  of filter_size words each, starting at base_addr, and drives one read handshake per word. It also

---
 rtl/fsc_pkg.sv | 16 +
 rtl/filter_elem_counter.sv | 22 ++
 rtl/filter_scan_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fsc_pkg.sv
// Shared types for the filter scan controller: FSM state encoding and config-latch widths.
package fsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } fsc_state_e;

  localparam int ADDR_W_DEF   = 16;
  localparam int SIZE_W_DEF   = 4;
  localparam int FCNT_W_DEF   = 8;
  localparam int REPEAT_W     = 8;

endpackage

// File: rtl/filter_elem_counter.sv
// Word-within-filter counter: clear has priority over increment; last flags idx == size-1.
module filter_elem_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] size,
  output logic [W-1:0] idx,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (rst)      idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= idx + W'(1);
  end

  assign last = (idx == (size - W'(1)));

endmodule

// File: rtl/filter_scan_controller.sv
// Walks num_filters filters of filter_size words from base_addr, one read handshake per word.
// Optional FILTER_REPEAT_EN: adds repeat_count and rescans each filter that many times.
module filter_scan_controller
  import fsc_pkg::*;
#(
  parameter int ADDR_WIDTH       = ADDR_W_DEF,
  parameter int MAX_FILTER_SIZE  = SIZE_W_DEF,
  parameter int FILTER_CNT_WIDTH = FCNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [MAX_FILTER_SIZE-1:0]  filter_size,
  input  logic [FILTER_CNT_WIDTH-1:0] num_filters,
`ifdef FILTER_REPEAT_EN
  input  logic [REPEAT_W-1:0]         repeat_count,
`endif
  input  logic                        rd_ready,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [ADDR_WIDTH-1:0]       filter_start_addr,
  output logic [FILTER_CNT_WIDTH-1:0] filter_idx,
  output logic [MAX_FILTER_SIZE-1:0]  elem_idx,
  output logic                        next_filter,
  output logic                        busy,
  output logic                        done
);

  fsc_state_e                  state, state_nx;
  logic [MAX_FILTER_SIZE-1:0]  cfg_size;
  logic [FILTER_CNT_WIDTH-1:0] cfg_num;
  logic launch, beat, elem_last, filter_last, last_pass;

  assign launch      = (state == IDLE) && start;
  assign beat        = (state == SCAN) && rd_ready;
  assign filter_last = (filter_idx == (cfg_num - FILTER_CNT_WIDTH'(1)));

`ifdef FILTER_REPEAT_EN
  logic [REPEAT_W-1:0] cfg_rep, pass_cnt;

  assign last_pass = (pass_cnt == (cfg_rep - REPEAT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rep  <= '0;
      pass_cnt <= '0;
    end else if (launch) begin
      cfg_rep  <= (repeat_count == '0) ? REPEAT_W'(1) : repeat_count;
      pass_cnt <= '0;
    end else if (state == GAP) begin
      pass_cnt <= last_pass ? '0 : pass_cnt + REPEAT_W'(1);
    end
  end
`else
  assign last_pass = 1'b1;
`endif

  // elem_idx holds size-1 through GAP/DONE and is zeroed on the edge leaving GAP.
  filter_elem_counter #(.W(MAX_FILTER_SIZE)) u_elem (
    .clk  (clk),
    .rst  (rst),
    .clr  (launch || (state == GAP)),
    .inc  (beat && !elem_last),
    .size (cfg_size),
    .idx  (elem_idx),
    .last (elem_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cfg_size          <= '0;
      cfg_num           <= '0;
      filter_start_addr <= '0;
      filter_idx        <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        cfg_size          <= filter_size;
        cfg_num           <= num_filters;
        filter_start_addr <= base_addr;
        filter_idx        <= '0;
      end else if ((state == GAP) && last_pass) begin
        filter_start_addr <= filter_start_addr + ADDR_WIDTH'(cfg_size);
        filter_idx        <= filter_idx + FILTER_CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    rd_en       = 1'b0;
    next_filter = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = ((filter_size == '0) || (num_filters == '0)) ? DONE : SCAN;
      end
      SCAN: begin
        rd_en = 1'b1;
        if (beat && elem_last)
          state_nx = (last_pass && filter_last) ? DONE : GAP;
      end
      GAP: begin
        next_filter = last_pass;
        state_nx    = SCAN;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_addr = filter_start_addr + ADDR_WIDTH'(elem_idx);

endmodule
